// File: rtl/baud_gen.sv
// baud_gen: programmable baud-rate generator with an oversample tick,
// a baud tick and a 50%-duty baud clock.
//
// The divisor D sets the oversample period in clki cycles. A new divisor is
// written into a shadow register and applied only at safe points, so a
// running baud period is never cut short.
//
// Ports:
//   clki        in   1      only clock, rising edge
//   resetn      in   1      synchronous active-low reset
//   en          in   1      run enable (IDLE <-> RUN)
//   restart     in   1      one-cycle phase realign strobe
//   div_in      in   WIDTH  new divisor value (0 is treated as 1)
//   div_wr      in   1      one-cycle write strobe for div_in
//   div_pending out  1      a written divisor waits to be applied
//   running     out  1      generator is in RUN
//   tick_os     out  1      one-cycle oversample pulse, period D
//   tick_baud   out  1      one-cycle baud pulse, period OVERSAMPLE*D
//   clko        out  1      baud square wave, falls together with tick_baud
module baud_gen #(
  parameter int WIDTH       = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 1250
) (
  input  logic             clki,
  input  logic             resetn,
  input  logic             en,
  input  logic             restart,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_wr,
  output logic             div_pending,
  output logic             running,
  output logic             tick_os,
  output logic             tick_baud,
  output logic             clko
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A zero divisor would stall the counter, so it is promoted to 1.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : v;
  endfunction

  localparam logic [WIDTH-1:0] RST_DIV = clamp_div(WIDTH'(DEFAULT_DIV));

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  div_act_q, div_act_d;
  logic [WIDTH-1:0]  div_shadow_q, div_shadow_d;
  logic [WIDTH-1:0]  os_cnt_q, os_cnt_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic              div_pending_q, div_pending_d;
  logic              running_q, running_d;
  logic              tick_os_q, tick_os_d;
  logic              tick_baud_q, tick_baud_d;
  logic              clko_q, clko_d;

  logic              os_zero_s;
  logic              baud_pt_s;
  logic              apply_s;
  logic [WIDTH-1:0]  d_eff_s;
  logic [WIDTH-1:0]  reload_s;

  // Next-state logic: apply point, divisor selection, counters and ticks.
  always_comb begin
    os_zero_s = (os_cnt_q == {WIDTH{1'b0}});
    // Edge that will raise tick_baud; restart suppresses it.
    baud_pt_s = (state_q == RUN) && en && !restart && os_zero_s && (ph_cnt_q == PH_LAST);
    apply_s   = div_pending_q && ((state_q == IDLE) || restart || baud_pt_s);
    // Any reload in the applying edge already uses the new divisor.
    d_eff_s   = apply_s ? div_shadow_q : div_act_q;
    reload_s  = d_eff_s - {{(WIDTH-1){1'b0}}, 1'b1};

    div_act_d    = d_eff_s;
    div_shadow_d = div_wr ? clamp_div(div_in) : div_shadow_q;
    // A write coinciding with an apply stays pending for the next point.
    div_pending_d = div_wr | (div_pending_q & ~apply_s);

    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    ph_cnt_d    = ph_cnt_q;
    tick_os_d   = 1'b0;
    tick_baud_d = 1'b0;
    clko_d      = clko_q;

    case (state_q)
      IDLE: begin
        os_cnt_d = reload_s;
        ph_cnt_d = {PH_W{1'b0}};
        clko_d   = 1'b0;
        if (en) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          state_d  = IDLE;
          os_cnt_d = reload_s;
          ph_cnt_d = {PH_W{1'b0}};
          clko_d   = 1'b0;
        end else if (restart) begin
          os_cnt_d = reload_s;
          ph_cnt_d = {PH_W{1'b0}};
          clko_d   = 1'b0;
        end else if (os_zero_s) begin
          os_cnt_d    = reload_s;
          tick_os_d   = 1'b1;
          tick_baud_d = (ph_cnt_q == PH_LAST);
          ph_cnt_d    = ph_cnt_q + {{(PH_W-1){1'b0}}, 1'b1};
          if (ph_cnt_q == PH_HALF) begin
            clko_d = 1'b1;
          end else if (ph_cnt_q == PH_LAST) begin
            clko_d = 1'b0;
          end else begin
            clko_d = clko_q;
          end
        end else begin
          os_cnt_d = os_cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d  = IDLE;
        os_cnt_d = reload_s;
        ph_cnt_d = {PH_W{1'b0}};
        clko_d   = 1'b0;
      end
    endcase

    running_d = (state_d == RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clki) begin
    if (!resetn) begin
      state_q       <= IDLE;
      div_act_q     <= RST_DIV;
      div_shadow_q  <= RST_DIV;
      os_cnt_q      <= RST_DIV - {{(WIDTH-1){1'b0}}, 1'b1};
      ph_cnt_q      <= {PH_W{1'b0}};
      div_pending_q <= 1'b0;
      running_q     <= 1'b0;
      tick_os_q     <= 1'b0;
      tick_baud_q   <= 1'b0;
      clko_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_act_q     <= div_act_d;
      div_shadow_q  <= div_shadow_d;
      os_cnt_q      <= os_cnt_d;
      ph_cnt_q      <= ph_cnt_d;
      div_pending_q <= div_pending_d;
      running_q     <= running_d;
      tick_os_q     <= tick_os_d;
      tick_baud_q   <= tick_baud_d;
      clko_q        <= clko_d;
    end
  end

  assign div_pending = div_pending_q;
  assign running     = running_q;
  assign tick_os     = tick_os_q;
  assign tick_baud   = tick_baud_q;
  assign clko        = clko_q;

endmodule

// File: tb/tb_baud_gen.sv
// Testbench for baud_gen (WIDTH=8, OVERSAMPLE=4, DEFAULT_DIV=3).
// A directed prologue walks through the documented scenarios, then random
// stimulus runs; every cycle all outputs are compared with a reference
// model that tracks absolute tick times.
module tb_baud_gen;

  localparam int W    = 8;
  localparam int OS   = 4;
  localparam int DDEF = 3;

  logic         clki = 1'b0;
  logic         resetn;
  logic         en;
  logic         restart;
  logic [W-1:0] div_in;
  logic         div_wr;
  logic         div_pending;
  logic         running;
  logic         tick_os;
  logic         tick_baud;
  logic         clko;

  int tests_run = 0;
  int tests_failed = 0;

  baud_gen #(.WIDTH(W), .OVERSAMPLE(OS), .DEFAULT_DIV(DDEF)) dut (
    .clki        (clki),
    .resetn      (resetn),
    .en          (en),
    .restart     (restart),
    .div_in      (div_in),
    .div_wr      (div_wr),
    .div_pending (div_pending),
    .running     (running),
    .tick_os     (tick_os),
    .tick_baud   (tick_baud),
    .clko        (clko)
  );

  always #5 clki = ~clki;

  // Reference model state: absolute edge count and time of next tick.
  int t_now = 0;
  int m_run, m_d, m_sh, m_pend, m_next, m_nticks;
  int m_tos, m_tb, m_clko;

  function automatic int clampd(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, t_now);
    end
  endtask

  // One rising edge worth of behaviour, using the inputs sampled at it.
  task automatic model_edge();
    int  apply;
    int  deff;
    t_now++;
    if (!resetn) begin
      m_run = 0; m_d = DDEF; m_sh = DDEF; m_pend = 0;
      m_tos = 0; m_tb = 0; m_clko = 0; m_nticks = 0; m_next = 0;
      return;
    end
    apply = 0;
    m_tos = 0;
    m_tb  = 0;
    if (m_run == 0) begin
      apply = 1;
    end else if (!en) begin
      apply = restart ? 1 : 0;
    end else if (restart) begin
      apply = 1;
    end else if (t_now == m_next && (m_nticks % OS) == OS - 1) begin
      apply = 1;
    end
    deff = (apply != 0 && m_pend != 0) ? m_sh : m_d;

    if (m_run == 0) begin
      m_clko = 0;
      if (en) begin
        m_run = 1; m_next = t_now + deff; m_nticks = 0;
      end
    end else if (!en) begin
      m_run = 0; m_clko = 0;
    end else if (restart) begin
      m_next = t_now + deff; m_nticks = 0; m_clko = 0;
    end else if (t_now == m_next) begin
      m_tos = 1;
      // Within a baud period of OS ticks, clko is high for the second half.
      if ((m_nticks % OS) == OS - 1) begin
        m_tb = 1; m_clko = 0;
      end else if ((m_nticks % OS) == OS / 2 - 1) begin
        m_clko = 1;
      end
      m_nticks++;
      m_next = t_now + deff;
    end

    if (apply != 0 && m_pend != 0) begin
      m_d = m_sh; m_pend = 0;
    end
    if (div_wr) begin
      m_sh = clampd(int'(div_in)); m_pend = 1;
    end
  endtask

  task automatic step();
    @(posedge clki);
    model_edge();
    #1;
    check_eq("tick_os", {31'd0, tick_os}, m_tos);
    check_eq("tick_baud", {31'd0, tick_baud}, m_tb);
    check_eq("clko", {31'd0, clko}, m_clko);
    check_eq("running", {31'd0, running}, m_run);
    check_eq("div_pending", {31'd0, div_pending}, m_pend);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_wr(input int v);
    div_in = W'(v); div_wr = 1'b1; step(); div_wr = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; restart = 1'b0; div_in = '0; div_wr = 1'b0;
    steps(2);
    resetn = 1'b1;
    // Default divisor run with a mid-period divisor write.
    en = 1'b1;
    steps(4);
    pulse_wr(5);
    steps(50);
    // Zero divisor written in IDLE, then run at D=1.
    en = 1'b0; steps(2);
    pulse_wr(0);
    en = 1'b1; steps(12);
    // Back to D=3 via IDLE, then restart mid-period.
    en = 1'b0; pulse_wr(3); steps(2);
    en = 1'b1; steps(7);
    restart = 1'b1; step(); restart = 1'b0;
    steps(15);
    // Enable drop mid-period.
    en = 1'b0; steps(3); en = 1'b1; steps(10);
    // Reset with a divisor pending.
    pulse_wr(6); steps(2);
    resetn = 1'b0; step(); resetn = 1'b1;
    steps(20);
    // Randomised phase.
    for (int i = 0; i < 4000; i++) begin
      resetn  = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 29) == 0) en = ~en;
      restart = ($urandom_range(0, 39) == 0);
      div_wr  = ($urandom_range(0, 24) == 0);
      div_in  = W'($urandom_range(0, 4));
      step();
    end
    resetn = 1'b1; restart = 1'b0; div_wr = 1'b0;
    steps(4);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 The module SHALL declare these parameters (name, default, meaning):
- WIDTH, 16: divisor width in bits.
- OVERSAMPLE, 16: tick_os pulses per baud period; even, power of two, >= 2.
- DEFAULT_DIV, 1250: divisor loaded at reset; 1200 baud x16 at 24 MHz.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clki, in, 1: the only clock; all logic on its rising edge.
- resetn, in, 1: synchronous, active-low reset.
- en, in, 1: run enable.
- restart, in, 1: one-cycle phase-realign strobe.
- div_in, in, WIDTH: new divisor value.
- div_wr, in, 1: one-cycle write strobe for div_in.
- div_pending, out, 1: a written divisor is waiting to be applied.
- running, out, 1: state == RUN.
- tick_os, out, 1: one-cycle oversample pulse.
- tick_baud, out, 1: one-cycle baud pulse.
- clko, out, 1: 50%-duty baud-rate square wave.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 The block SHALL hold two internal registers, div_act and div_shadow (WIDTH bits), a down-counter os_cnt (WIDTH bits) and a phase counter ph_cnt (log2(OVERSAMPLE) bits).
REQ-005 A divisor value of 0 SHALL be treated as 1 wherever it is captured; the effective divisor is D = div_act.
REQ-006 States SHALL be IDLE and RUN.
- IDLE->RUN: en=1.
- RUN->IDLE: en=0.
- The transition takes effect on the clock edge where en is sampled.
REQ-007 In IDLE:
- os_cnt = D-1, ph_cnt = 0.
- tick_os = tick_baud = clko = 0.
REQ-008 In RUN, when os_cnt != 0: os_cnt SHALL decrement by 1.
REQ-009 In RUN, when os_cnt == 0: os_cnt SHALL reload D-1 and tick_os SHALL be 1 for exactly one cycle.
REQ-010 The period of tick_os SHALL be exactly D clki cycles; the first tick_os SHALL occur D cycles after the edge that enters RUN.
REQ-011 On each tick_os, ph_cnt SHALL increment modulo OVERSAMPLE.
REQ-012 tick_baud SHALL be asserted coincident with the tick_os for which ph_cnt == OVERSAMPLE-1 (pre-increment); its period SHALL be OVERSAMPLE*D cycles.
REQ-013 clko SHALL change only on tick_os:
- It SHALL be set to 1 when ph_cnt == OVERSAMPLE/2-1.
- It SHALL be cleared to 0 when ph_cnt == OVERSAMPLE-1.
- Its falling edge SHALL therefore coincide with tick_baud.
REQ-014 div_wr=1 SHALL capture div_in (0 clamped to 1) into div_shadow and SHALL set div_pending on the next cycle. A write while already pending SHALL overwrite div_shadow (last write wins).
REQ-015 A pending divisor SHALL be applied (div_act <= div_shadow, div_pending <= 0) at one of these points:
- the edge asserting tick_baud;
- any edge in IDLE;
- a restart.
The reload in that same edge SHALL use the new value.
REQ-016 If div_wr coincides with an apply point, the apply SHALL use the previous div_shadow and the new write SHALL leave div_pending = 1.
REQ-017 restart=1 in RUN SHALL force:
- os_cnt = D-1, where D is the value after any pending apply;
- ph_cnt = 0, clko = 0;
- no tick that cycle.
restart SHALL take priority over tick generation.
REQ-018 restart in IDLE SHALL be ignored except for the pending apply.
REQ-019 en falling mid-period SHALL abandon the period with no tick; the next RUN entry SHALL start a full D-cycle count.
REQ-020 No output SHALL be X after the first reset edge, and no reliance on declaration initial values is permitted.

Reset
REQ-021 resetn=0 sampled on clki SHALL force:
- state = IDLE;
- div_act = div_shadow = DEFAULT_DIV;
- os_cnt = DEFAULT_DIV-1, ph_cnt = 0;
- div_pending = running = tick_os = tick_baud = clko = 0.
REQ-022 Reset SHALL override en, restart and div_wr in the same cycle.
REQ-023 Reset asserted mid-period SHALL discard any pending divisor.

Verification (bench: OVERSAMPLE=4, DEFAULT_DIV=3, WIDTH=8)
- V1: reset, then en=1 held -> tick_os on cycles 3, 6, 9, 12; tick_baud on cycle 12; clko rises at 6, falls at 12, period 12 cycles.
- V2: div_wr with div_in=5 at cycle 4 while running -> div_pending=1 from cycle 5 until tick_baud at 12; afterwards tick_os every 5 cycles and tick_baud every 20.
- V3: div_in=0 written in IDLE -> D=1; tick_os every cycle after en; clko toggles every 2 cycles.
- V4: restart at cycle 7 -> no tick at 7; next tick_os at 10, ph_cnt=0, clko=0; first tick_baud at 19.
- V5: en dropped at cycle 5, raised at 8 -> no ticks 5..10; next tick_os at 11.
- V6: resetn=0 for one cycle mid-period with a divisor pending -> all outputs 0, div_pending=0, D=3 restored.
